// File: rtl/ciphertext_loader_if.sv
// Bundle of the receive handshake, codebreaker handshake and status/ciphertext outputs
// of the ciphertext loader.
interface ciphertext_loader_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_parity_err;
  logic         rx_ack;
  logic         cb_done;
  logic         start;
  logic [127:0] ciphertext;
  logic [4:0]   byte_count;
  logic         frame_err;
  logic         overrun;

  modport master (
    output rx_data, rx_valid, rx_parity_err, cb_done,
    input  rx_ack, start, ciphertext, byte_count, frame_err, overrun
  );

  modport slave (
    input  rx_data, rx_valid, rx_parity_err, cb_done,
    output rx_ack, start, ciphertext, byte_count, frame_err, overrun
  );
endinterface

// File: rtl/ciphertext_loader.sv
// Assembles 16 received bytes into a 128-bit ciphertext block and launches the codebreaker.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module ciphertext_loader #(
  parameter int unsigned  CLK_FREQUENCY   = 100_000_000,
  parameter int unsigned  WAIT_TIME_US    = 5_000,
  parameter logic [127:0] INIT_CIPHERTEXT = 128'ha13a3ab3071897088f3233a58d6238bb
) (
  input logic                clk,
  input logic                rst,
  ciphertext_loader_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRecv, StLaunch, StWaitDone} state_e;

  state_e       state_q, state_d;
  logic [127:0] shreg_q, shreg_d;
  logic [127:0] ct_q, ct_d;
  logic [4:0]   count_q, count_d;
  logic         armed_q;
  logic         ack_q, ack_d;
  logic         start_q, start_d;
  logic         ferr_q, ferr_d;
  logic         ovr_q, ovr_d;
  logic         capture;
  logic         timeout;

  // armed re-arms on any edge with rx_valid low, so a held byte is taken only once
  assign capture = bus.rx_valid & armed_q;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned Limit  = WAIT_TIME_US * (CLK_FREQUENCY / 1_000_000);
  localparam int unsigned TimerW = (Limit > 1) ? $clog2(Limit) : 1;

  logic [TimerW-1:0] timer_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
    end else if (state_q != StRecv || capture) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  assign timeout = (state_q == StRecv) && (timer_q == TimerW'(Limit - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    ct_d    = ct_q;
    count_d = count_q;
    ack_d   = capture;
    start_d = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;
    case (state_q)
      StIdle, StRecv: begin
        if (capture) begin
          if (bus.rx_parity_err) begin
            count_d = 5'd0;
            ferr_d  = 1'b1;
            state_d = StIdle;
          end else begin
            shreg_d = {shreg_q[119:0], bus.rx_data};
            count_d = count_q + 5'd1;
            if (count_q == 5'd15) begin
              ct_d    = {shreg_q[119:0], bus.rx_data};
              state_d = StLaunch;
            end else begin
              state_d = StRecv;
            end
          end
        end else if (timeout) begin
          count_d = 5'd0;
          ferr_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StLaunch: begin
        start_d = 1'b1;
        state_d = StWaitDone;
        if (capture) ovr_d = 1'b1;
      end
      StWaitDone: begin
        if (capture) ovr_d = 1'b1;
        if (bus.cb_done) begin
          count_d = 5'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      ct_q    <= INIT_CIPHERTEXT;
      count_q <= 5'd0;
      armed_q <= 1'b1;
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      ct_q    <= ct_d;
      count_q <= count_d;
      armed_q <= ~bus.rx_valid;
      ack_q   <= ack_d;
      start_q <= start_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.rx_ack     = ack_q;
  assign bus.start      = start_q;
  assign bus.ciphertext = ct_q;
  assign bus.byte_count = count_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_ciphertext_loader.sv
// Self-checking bench for ciphertext_loader: directed and random frames against a
// queue-based model of the loader's frame/commit behaviour.
module tb_ciphertext_loader;

  localparam logic [127:0] Init = 128'ha13a3ab3071897088f3233a58d6238bb;
`ifdef LOADER_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic clk;
  logic rst;
  ciphertext_loader_if bus ();

  ciphertext_loader #(
    .CLK_FREQUENCY  (100_000_000),
    .WAIT_TIME_US   (1),
    .INIT_CIPHERTEXT(Init)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Model: bytes of the current partial frame, last committed block, busy flag.
  logic [7:0]   frame_q[$];
  logic [127:0] exp_ct = Init;
  bit           busy   = 1'b0;
  bit           exp_ovr = 1'b0;

  function automatic logic [4:0] exp_count();
    return busy ? 5'd16 : 5'(frame_q.size());
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte, holding rx_valid for 'hold' edges, and check every edge it spans.
  task automatic send(input logic [7:0] d, input bit perr, input int hold);
    bit launched;
    bit ferr;
    launched = 1'b0;
    ferr     = 1'b0;
    @(negedge clk);
    bus.rx_data       = d;
    bus.rx_valid      = 1'b1;
    bus.rx_parity_err = perr;
    @(posedge clk);
    #1;
    if (busy) begin
      exp_ovr = 1'b1;
    end else if (perr) begin
      frame_q.delete();
      ferr = 1'b1;
    end else begin
      frame_q.push_back(d);
      if (frame_q.size() == 16) begin
        exp_ct = '0;
        foreach (frame_q[i]) exp_ct = {exp_ct[119:0], frame_q[i]};
        frame_q.delete();
        busy     = 1'b1;
        launched = 1'b1;
      end
    end
    check("cap_ack", bus.rx_ack, 1'b1);
    check("cap_count", bus.byte_count, exp_count());
    check("cap_ferr", bus.frame_err, ferr);
    check("cap_ct", bus.ciphertext, exp_ct);
    check("cap_ovr", bus.overrun, exp_ovr);
    check("cap_start", bus.start, 1'b0);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_ack", bus.rx_ack, 1'b0);
      check("hold_count", bus.byte_count, exp_count());
      check("hold_start", bus.start, launched && i == 1);
    end
    @(negedge clk);
    bus.rx_valid      = 1'b0;
    bus.rx_parity_err = 1'b0;
    @(posedge clk);
    #1;
    check("post_ack", bus.rx_ack, 1'b0);
    check("post_start", bus.start, launched && hold == 1);
    check("post_ferr", bus.frame_err, 1'b0);
  endtask

  task automatic done_pulse();
    @(negedge clk);
    bus.cb_done = 1'b1;
    @(posedge clk);
    #1;
    busy = 1'b0;
    check("done_count", bus.byte_count, exp_count());
    check("done_start", bus.start, 1'b0);
    check("done_ovr", bus.overrun, exp_ovr);
    check("done_ct", bus.ciphertext, exp_ct);
    @(negedge clk);
    bus.cb_done = 1'b0;
  endtask

  initial begin
    logic [127:0] seq_ct;
    seq_ct            = 128'h000102030405060708090a0b0c0d0e0f;
    bus.rx_data       = 8'h00;
    bus.rx_valid      = 1'b0;
    bus.rx_parity_err = 1'b0;
    bus.cb_done       = 1'b0;
    rst               = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ct", bus.ciphertext, Init);
    check("rst_ack", bus.rx_ack, 1'b0);
    check("rst_start", bus.start, 1'b0);
    check("rst_ferr", bus.frame_err, 1'b0);
    check("rst_ovr", bus.overrun, 1'b0);
    check("rst_count", bus.byte_count, 5'd0);
    @(negedge clk);
    rst = 1'b1;

    // Sequential frame 0x00..0x0F
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1);
    check("seq_ct", bus.ciphertext, seq_ct);
    repeat (4) @(posedge clk);
    #1;
    check("seq_count16", bus.byte_count, 5'd16);

    // Byte while codebreaker busy, then release
    send(8'h5a, 1'b0, 1);
    check("ovr_set", bus.overrun, 1'b1);
    check("ovr_ct", bus.ciphertext, seq_ct);
    done_pulse();

    // cb_done in idle is ignored
    done_pulse();

    // Held byte captured once, then partial frame aborted by parity error
    send(8'hc3, 1'b0, 10);
    check("hold_one", bus.byte_count, 5'd1);
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0, 1);
    check("five", bus.byte_count, 5'd5);
    send(8'hee, 1'b1, 1);
    check("perr_count", bus.byte_count, 5'd0);
    check("perr_ct", bus.ciphertext, seq_ct);

    // Random frames with occasional parity errors
    for (int f = 0; f < 4; f++) begin
      while (!busy) send(8'($urandom), $urandom_range(0, 19) == 0, $urandom_range(1, 3));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      done_pulse();
    end

    // Three bytes, then an idle gap that crosses the timeout limit
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 1);
    for (int k = 2; k <= 105; k++) begin
      @(posedge clk);
      #1;
      if (ToEn && k == 100) frame_q.delete();
      check("to_ferr", bus.frame_err, ToEn && k == 100);
      check("to_count", bus.byte_count, exp_count());
    end
    send(8'h11, 1'b1, 1);
    check("to_end_count", bus.byte_count, 5'd0);
    check("to_end_ovr", bus.overrun, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
